cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 5, clock-enable divide ratio (100 MHz clk -> 20 MHz CPU step rate); legal range 2..255.
REQ-002 SHALL have parameter HALT_ADDR, default 32'h0000_0064, data address whose store ends the program.
REQ-003 SHALL have parameter PASS_DATA, default 32'h0000_0019, store value meaning pass.
REQ-004 SHALL have parameter MAX_CYCLES, default 2000, watchdog limit in CPU steps.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Start  input  1  level sampled each clk; start/resume/clear.
REQ-008 SHALL have port Stop  input  1  pause request.
REQ-009 SHALL have port Step  input  1  single-step request, valid only in PAUSE.
REQ-010 SHALL have ports MemWrite  input  1, DataAddr  input  32, WriteData  input  32, driven from the single-cycle CPU's data-memory port.
REQ-011 SHALL have port CpuEn  output  1  registered CPU clock enable.
REQ-012 SHALL have port CpuReset  output  1  registered, active-high CPU reset.
REQ-013 SHALL have ports State  output  2, Done  output  1, Pass  output  1, Timeout  output  1, CycleCount  output  32.

Function
REQ-014 SHALL implement states IDLE=0, RUN=1, PAUSE=2, HALT=3.
REQ-015 IDLE SHALL hold CpuReset=1, CpuEn=0; Start -> RUN, clearing CycleCount, divider, Done, Pass, Timeout.
REQ-016 RUN SHALL run a divider counter 0..DIV-1, asserting CpuEn for exactly one clk when the counter wraps (one pulse per DIV clks, first pulse DIV clks after entering RUN); CpuReset=0.
REQ-017 Halt check SHALL apply only on a clk where CpuEn=1: MemWrite=1 and DataAddr==HALT_ADDR -> HALT next edge, Done=1, Pass=(WriteData==PASS_DATA); other addresses never halt.
REQ-018 RUN with Stop -> PAUSE, divider frozen; a simultaneous halt match SHALL win over Stop.
REQ-019 PAUSE SHALL hold CpuReset=0; Start -> RUN (resume, counters kept); Step -> exactly one CpuEn pulse on the next clk; Step held high SHALL give one pulse per rising edge of Step; Start and Step together: Start wins.
REQ-020 Step-generated pulses SHALL be subject to the halt check and counted in CycleCount.
REQ-021 HALT SHALL hold CpuEn=0, CpuReset=0 (CPU state preserved); Start -> IDLE; Stop and Step ignored.
REQ-022 CycleCount SHALL increment on every CpuEn pulse, saturating at 32'hFFFF_FFFF.
REQ-023 Step in RUN/IDLE/HALT and Stop in IDLE/PAUSE/HALT SHALL be ignored.

Reset
REQ-024 reset low SHALL force immediately (no clock): State=IDLE, CpuReset=1, CpuEn=0, Done=0, Pass=0, Timeout=0, CycleCount=0, divider=0, including mid-RUN.
REQ-025 Deassertion SHALL be released cleanly; first state change no earlier than the first clk edge after release.

Configuration
REQ-026 With CYCLE_LIMIT_EN defined, in RUN when CycleCount reaches MAX_CYCLES -> HALT, Done=1, Pass=0, Timeout=1; a halt match on the same pulse SHALL take precedence (Timeout=0).
REQ-027 Without CYCLE_LIMIT_EN, no watchdog logic SHALL exist, Timeout tied 0, MAX_CYCLES unused.

Structure
REQ-028 State encoding, default HALT_ADDR/PASS_DATA constants SHALL live in shared package riscv_ctrl_pkg.
REQ-029 Divider SHALL be sub-module clk_en_div (inputs run, clear; output tick).

Verification
REQ-030 reset low 22 ns then high, Start=1 -> CpuReset falls next edge, CpuEn pulses every 5 clks, CycleCount=4 after 20 clks.
REQ-031 During CpuEn: MemWrite=1, DataAddr=100, WriteData=25 -> State=HALT, Done=1, Pass=1, CpuEn stays 0.
REQ-032 Store DataAddr=96 -> keeps running; store DataAddr=100, WriteData=7 -> Done=1, Pass=0.
REQ-033 RUN, Stop -> PAUSE; three Step pulses -> exactly 3 CpuEn pulses, CycleCount +3; Start -> RUN resumes cadence.
REQ-034 CYCLE_LIMIT_EN, MAX_CYCLES=2000, no halt store -> Timeout=1, Done=1 after pulse 2000; without macro still RUN after 2000.
REQ-035 reset low mid-RUN, asynchronous to clk -> all outputs at reset values before next edge; Start afterwards restarts from CycleCount=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encoding,
// default halt/pass constants, divider width and a saturating increment.
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } run_state_t;

    localparam logic [31:0] DEF_HALT_ADDR  = 32'h0000_0064;
    localparam logic [31:0] DEF_PASS_DATA  = 32'h0000_0019;
    localparam int unsigned DEF_DIV        = 5;
    localparam int unsigned DEF_MAX_CYCLES = 2000;

    localparam int unsigned DIV_W     = 8;
    localparam logic [31:0] CYCLE_SAT = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CYCLE_SAT) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: counts 0..DIV-1 while run is high, tick marks
// the wrap cycle. Ports: clk, rst_n (async low), run, clear, tick.
module clk_en_div
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
)(
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick = run & ~clear & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/pause/step/halt controller for a single-cycle CPU, driving its
// clock enable and reset and watching its data port for the halt store.
// Ports: clk, reset (async low), Start, Stop, Step, MemWrite, DataAddr,
// WriteData in; CpuEn, CpuReset, State, Done, Pass, Timeout, CycleCount
// out. Define CYCLE_LIMIT_EN to build the MAX_CYCLES watchdog.
module cpu_run_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned DIV        = DEF_DIV,
    parameter logic [31:0] HALT_ADDR  = DEF_HALT_ADDR,
    parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Step,
    input  logic        MemWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    output logic        CpuEn,
    output logic        CpuReset,
    output logic [1:0]  State,
    output logic        Done,
    output logic        Pass,
    output logic        Timeout,
    output logic [31:0] CycleCount
);

    if (DIV < 2 || DIV > 255) begin : g_bad_div
        $error("cpu_run_ctrl: DIV out of range 2..255");
    end
    if (MAX_CYCLES == 0) begin : g_bad_max
        $error("cpu_run_ctrl: MAX_CYCLES must be nonzero");
    end

    run_state_t  state;
    run_state_t  nxt;
    logic        en_n;
    logic        done_n;
    logic        pass_n;
    logic        clr;
    logic        tick;
    logic        step_q;
    logic        step_rise;
    logic        halt_hit;
    logic        pass_hit;
    logic [31:0] cnt_n;

    assign State     = state;
    assign step_rise = Step & ~step_q;
    assign pass_hit  = (WriteData == PASS_DATA);
    // Only a store issued by a live CPU step can end the program.
    assign halt_hit  = CpuEn & MemWrite & (DataAddr == HALT_ADDR);

    clk_en_div #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (reset),
        .run   (state == ST_RUN),
        .clear (clr),
        .tick  (tick)
    );

`ifdef CYCLE_LIMIT_EN
    logic timeout_q;
    logic to_n;
    logic wdog;

    assign wdog    = CpuEn & (CycleCount >= MAX_CYCLES);
    assign Timeout = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_n;
        end
    end
`else
    assign Timeout = 1'b0;
`endif

    always_comb begin
        nxt    = state;
        en_n   = 1'b0;
        done_n = Done;
        pass_n = Pass;
        clr    = 1'b0;
`ifdef CYCLE_LIMIT_EN
        to_n   = timeout_q;
`endif
        unique case (state)
            ST_IDLE: begin
                if (Start) begin
                    nxt    = ST_RUN;
                    clr    = 1'b1;
                    done_n = 1'b0;
                    pass_n = 1'b0;
`ifdef CYCLE_LIMIT_EN
                    to_n   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    nxt    = ST_HALT;
                    done_n = 1'b1;
                    pass_n = pass_hit;
`ifdef CYCLE_LIMIT_EN
                    to_n   = 1'b0;
                end else if (wdog) begin
                    nxt    = ST_HALT;
                    done_n = 1'b1;
                    pass_n = 1'b0;
                    to_n   = 1'b1;
`endif
                end else begin
                    en_n = tick;
                    if (Stop) begin
                        nxt = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (halt_hit) begin
                    nxt    = ST_HALT;
                    done_n = 1'b1;
                    pass_n = pass_hit;
`ifdef CYCLE_LIMIT_EN
                    to_n   = 1'b0;
`endif
                end else if (Start) begin
                    nxt = ST_RUN;
                end else if (step_rise) begin
                    en_n = 1'b1;
                end
            end
            ST_HALT: begin
                if (Start) begin
                    nxt = ST_IDLE;
                end
            end
        endcase
    end

    // The count advances with the pulse itself, so it already includes
    // the step the CPU is executing while CpuEn is high.
    always_comb begin
        cnt_n = CycleCount;
        if (clr) begin
            cnt_n = '0;
        end else if (en_n) begin
            cnt_n = sat_inc(CycleCount);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            CpuEn      <= 1'b0;
            CpuReset   <= 1'b1;
            Done       <= 1'b0;
            Pass       <= 1'b0;
            CycleCount <= '0;
            step_q     <= 1'b0;
        end else begin
            state      <= nxt;
            CpuEn      <= en_n;
            CpuReset   <= (nxt == ST_IDLE);
            Done       <= done_n;
            Pass       <= pass_n;
            CycleCount <= cnt_n;
            step_q     <= Step;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected pulses and state snapshots
// are queued by the stimulus and checked by a negedge monitor.
module tb_cpu_run_ctrl;

    bit          clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        Stop;
    logic        Step;
    logic        MemWrite;
    logic [31:0] DataAddr;
    logic [31:0] WriteData;
    logic        CpuEn;
    logic        CpuReset;
    logic [1:0]  State;
    logic        Done;
    logic        Pass;
    logic        Timeout;
    logic [31:0] CycleCount;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    typedef struct {
        int          id;
        logic [1:0]  st;
        logic        en;
        logic        rst;
        logic        done;
        logic        pass;
        logic        to;
        logic [31:0] cnt;
    } snap_t;

    typedef struct {
        int          e_no;
        logic [31:0] cnt;
    } pulse_t;

    snap_t  sq[$];
    pulse_t pq[$];
    int     ecnt = 0;
    int     n_chk = 0;
    int     n_pass = 0;

    cpu_run_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .Stop       (Stop),
        .Step       (Step),
        .MemWrite   (MemWrite),
        .DataAddr   (DataAddr),
        .WriteData  (WriteData),
        .CpuEn      (CpuEn),
        .CpuReset   (CpuReset),
        .State      (State),
        .Done       (Done),
        .Pass       (Pass),
        .Timeout    (Timeout),
        .CycleCount (CycleCount)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic wait_edge(input int n);
        while (ecnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_snap(input int id, input logic [1:0] st,
                            input logic en, input logic rst,
                            input logic done, input logic pass,
                            input logic to, input logic [31:0] cnt);
        snap_t s;
        s.id = id; s.st = st; s.en = en; s.rst = rst;
        s.done = done; s.pass = pass; s.to = to; s.cnt = cnt;
        sq.push_back(s);
    endtask

    task automatic exp_pulse(input int e, input logic [31:0] cnt);
        pulse_t p;
        p.e_no = e;
        p.cnt  = cnt;
        pq.push_back(p);
    endtask

    // Monitor: every CpuEn pulse must match the next queued pulse, and
    // every queued snapshot is compared at the following negedge.
    initial forever begin
        pulse_t p;
        snap_t  s;
        @(negedge clk);
        if (CpuEn === 1'b1) begin
            n_chk++;
            if (pq.size() == 0) begin
                $display("FAIL pulse_extra edge=%0d cnt=%0d required none",
                         ecnt, CycleCount);
            end else begin
                p = pq.pop_front();
                if (ecnt == p.e_no && CycleCount === p.cnt) begin
                    n_pass++;
                end else begin
                    $display("FAIL pulse edge=%0d cnt=%0d required edge=%0d cnt=%0d",
                             ecnt, CycleCount, p.e_no, p.cnt);
                end
            end
        end
        while (sq.size() > 0) begin
            s = sq.pop_front();
            n_chk++;
            if (State === s.st && CpuEn === s.en && CpuReset === s.rst &&
                Done === s.done && Pass === s.pass &&
                Timeout === s.to && CycleCount === s.cnt) begin
                n_pass++;
            end else begin
                $display("FAIL snap%0d got st=%0d en=%b rst=%b done=%b pass=%b to=%b cnt=%0d required st=%0d en=%b rst=%b done=%b pass=%b to=%b cnt=%0d",
                         s.id, State, CpuEn, CpuReset, Done, Pass, Timeout,
                         CycleCount, s.st, s.en, s.rst, s.done, s.pass,
                         s.to, s.cnt);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL sim_timeout edge=%0d required finish", ecnt);
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b0; Start = 1'b0; Stop = 1'b0; Step = 1'b0;
        MemWrite = 1'b0; DataAddr = '0; WriteData = '0;
        exp_snap(0, S_IDLE, 0, 1, 0, 0, 0, 0);
        #22;
        reset = 1'b1;
        Start = 1'b1;
        for (int k = 1; k <= 6; k++) exp_pulse(3 + 5 * k, k);

        wait_edge(3);
        Start = 1'b0;
        exp_snap(1, S_RUN, 0, 0, 0, 0, 0, 0);

        wait_edge(23);
        exp_snap(2, S_RUN, 1, 0, 0, 0, 0, 4);

        wait_edge(24);
        MemWrite = 1'b1; DataAddr = 32'd96; WriteData = 32'd25;

        wait_edge(33);
        exp_snap(3, S_RUN, 1, 0, 0, 0, 0, 6);
        MemWrite = 1'b0;
        Stop = 1'b1;

        wait_edge(34);
        Stop = 1'b0;
        exp_snap(4, S_PAUSE, 0, 0, 0, 0, 0, 6);
        exp_pulse(37, 7);
        exp_pulse(43, 8);
        exp_pulse(46, 9);

        wait_edge(36); Step = 1'b1;
        wait_edge(40); Step = 1'b0;
        wait_edge(42); Step = 1'b1;
        wait_edge(43); Step = 1'b0;
        wait_edge(45); Step = 1'b1;
        wait_edge(46); Step = 1'b0;
        exp_snap(5, S_PAUSE, 1, 0, 0, 0, 0, 9);

        wait_edge(47); Stop = 1'b1;
        wait_edge(48);
        Stop = 1'b0; Start = 1'b1; Step = 1'b1;
        exp_pulse(53, 10);
        exp_pulse(58, 11);

        wait_edge(49);
        Start = 1'b0; Step = 1'b0;
        exp_snap(6, S_RUN, 0, 0, 0, 0, 0, 9);

        wait_edge(54); Step = 1'b1;
        wait_edge(55); Step = 1'b0;

        wait_edge(58);
        MemWrite = 1'b1; DataAddr = 32'd100; WriteData = 32'd7;

        wait_edge(59);
        MemWrite = 1'b0;
        exp_snap(7, S_HALT, 0, 0, 1, 0, 0, 11);

        wait_edge(60); Stop = 1'b1; Step = 1'b1;
        wait_edge(62); Stop = 1'b0; Step = 1'b0;
        exp_snap(8, S_HALT, 0, 0, 1, 0, 0, 11);

        wait_edge(63); Start = 1'b1;
        wait_edge(64);
        exp_snap(9, S_IDLE, 0, 1, 1, 0, 0, 11);
        exp_pulse(70, 1);
        exp_pulse(75, 2);

        wait_edge(65);
        Start = 1'b0;
        exp_snap(10, S_RUN, 0, 0, 0, 0, 0, 0);

        wait_edge(75);
        MemWrite = 1'b1; DataAddr = 32'd100; WriteData = 32'd25;
        Stop = 1'b1;

        wait_edge(76);
        MemWrite = 1'b0; Stop = 1'b0;
        exp_snap(11, S_HALT, 0, 0, 1, 1, 0, 2);

        wait_edge(80);
        exp_snap(12, S_HALT, 0, 0, 1, 1, 0, 2);

        wait_edge(81); Start = 1'b1;
        wait_edge(83);
        Start = 1'b0;
        for (int k = 1; k <= 2000; k++) exp_pulse(83 + 5 * k, k);
`ifndef CYCLE_LIMIT_EN
        exp_pulse(10088, 2001);
`endif

        wait_edge(10084);
`ifdef CYCLE_LIMIT_EN
        exp_snap(13, S_HALT, 0, 0, 1, 0, 1, 2000);
`else
        exp_snap(13, S_RUN, 0, 0, 0, 0, 0, 2000);
        wait_edge(10088);
        exp_snap(14, S_RUN, 1, 0, 0, 0, 0, 2001);
`endif

        wait_edge(10090);
        #2;
        reset = 1'b0;
        exp_snap(15, S_IDLE, 0, 1, 0, 0, 0, 0);

        wait_edge(10092);
        reset = 1'b1;
        Start = 1'b1;
        exp_pulse(10098, 1);

        wait_edge(10093);
        Start = 1'b0;
        exp_snap(16, S_RUN, 0, 0, 0, 0, 0, 0);

        wait_edge(10098);
        exp_snap(17, S_RUN, 1, 0, 0, 0, 0, 1);

        wait_edge(10100);
        n_chk++;
        if (pq.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL pulse_missing left=%0d required 0 next_edge=%0d",
                     pq.size(), pq[0].e_no);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
